// File: rtl/sum_accum_if.sv
// sum_accum_if: handshake bundle between the adder-sum source, the frame accumulator
// and the frame-total sink.
//   iEn    - input-side enable (source -> block)
//   iClr   - synchronous clear (source -> block)
//   iValid - iData carries a sum (source -> block)
//   iData  - unsigned IBITWIDTH-bit sum (source -> block)
//   oReady - block accepts iData this cycle (block -> source)
//   oValid - oData holds a completed frame total (block -> sink)
//   oData  - unsigned OBITWIDTH-bit frame total (block -> sink)
//   iReady - sink takes oData this cycle (sink -> block)
// Modport slave is the accumulator side, master is the environment side.
interface sum_accum_if #(
  parameter int unsigned IBITWIDTH = 33,
  parameter int unsigned ACCLEN    = 4
);
  localparam int unsigned OBITWIDTH = IBITWIDTH + $clog2(ACCLEN);

  logic                 iEn;
  logic                 iClr;
  logic                 iValid;
  logic [IBITWIDTH-1:0] iData;
  logic                 oReady;
  logic                 oValid;
  logic [OBITWIDTH-1:0] oData;
  logic                 iReady;

  modport slave (
    input  iEn, iClr, iValid, iData, iReady,
    output oReady, oValid, oData
  );

  modport master (
    output iEn, iClr, iValid, iData, iReady,
    input  oReady, oValid, oData
  );
endinterface

// File: rtl/sum_accum.sv
// sum_accum: accumulates ACCLEN consecutive accepted adder sums into one frame total and
// presents it through a one-entry output register with a valid/ready handshake. The next
// frame keeps accumulating while the previous total waits for the sink.
// Ports:
//   iClk  - clock, rising edge
//   iRstN - asynchronous active-low reset
//   bus   - sum_accum_if.slave: iEn/iClr/iValid/iData/oReady on the input side,
//           oValid/oData/iReady on the output side
// ACCLEN must be >= 2.
module sum_accum #(
  parameter int unsigned IBITWIDTH = 33,
  parameter int unsigned ACCLEN    = 4
) (
  input logic         iClk,
  input logic         iRstN,
  sum_accum_if.slave  bus
);
  localparam int unsigned OBITWIDTH = IBITWIDTH + $clog2(ACCLEN);
  localparam int unsigned CntW      = $clog2(ACCLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(ACCLEN - 1);

  logic [OBITWIDTH-1:0] r_acc, w_acc_d;
  logic [OBITWIDTH-1:0] r_data, w_data_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic                 r_valid, w_valid_d;
  logic [OBITWIDTH-1:0] w_sum;
  logic                 w_last, w_stall, w_ready, w_accept;

  assign w_last = (r_cnt == LastCnt);
  // Only the frame-completing sample must wait for the output register to be free;
  // iReady frees it in the same cycle, hence the combinational iReady->oReady path.
  assign w_stall  = w_last & r_valid & ~bus.iReady;
  assign w_ready  = bus.iEn & ~bus.iClr & ~w_stall;
  assign w_accept = bus.iValid & w_ready;
  assign w_sum    = r_acc + OBITWIDTH'(bus.iData);

  always_comb begin
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_valid_d = r_valid;
    if (bus.iClr) begin
      w_acc_d   = '0;
      w_cnt_d   = '0;
      w_data_d  = '0;
      w_valid_d = 1'b0;
    end else begin
      // Drain first; a completing frame below overrides it so there is no bubble.
      if (r_valid && bus.iReady) begin
        w_valid_d = 1'b0;
      end
      if (w_accept) begin
        if (w_last) begin
          w_data_d  = w_sum;
          w_valid_d = 1'b1;
          w_acc_d   = '0;
          w_cnt_d   = '0;
        end else begin
          w_acc_d = w_sum;
          w_cnt_d = r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
    end
  end

  assign bus.oReady = w_ready;
  assign bus.oValid = r_valid;
  assign bus.oData  = r_data;
endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: scoreboard bench for sum_accum (IBITWIDTH=33, ACCLEN=4). Stimulus pushes
// the expected frame totals; a negedge monitor pops and compares on every output handshake.
module tb_sum_accum;
  localparam int unsigned IW = 33;
  localparam int unsigned AL = 4;
  localparam int unsigned OW = 35;

  logic iClk = 1'b0;
  logic iRstN;
  always #5 iClk = ~iClk;

  sum_accum_if #(.IBITWIDTH(IW), .ACCLEN(AL)) bus ();

  sum_accum #(.IBITWIDTH(IW), .ACCLEN(AL)) u_dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a handshake is completed at the next rising edge unless clear or reset hits.
  always @(negedge iClk) begin
    if (iRstN === 1'b1 && bus.oValid === 1'b1 && bus.iReady === 1'b1 && bus.iClr === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_total: got 0x%0h, expected none", bus.oData);
      end else begin
        check("frame_total", 64'(bus.oData), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // Presents one sample and holds it until accepted; returns at edge+1 after acceptance.
  task automatic send(input logic [IW-1:0] d, input bit rnd_ready);
    int waited = 0;
    bus.iValid = 1'b1;
    bus.iData  = d;
    if (rnd_ready) bus.iReady = 1'($urandom_range(0, 1));
    #1;
    while (bus.oReady !== 1'b1 && waited < 50) begin
      cycle();
      waited++;
      if (rnd_ready) bus.iReady = 1'($urandom_range(0, 1));
      #1;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got oReady=0 for 50 cycles, expected acceptance");
    end
    cycle();
    bus.iValid = 1'b0;
  endtask

  initial begin
    logic [63:0]   r;
    logic [IW-1:0] d[4];
    logic [OW-1:0] sum;
    int            w;

    // Reset with random inputs
    iRstN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = {$urandom(), $urandom()};
      bus.iEn    = r[0];
      bus.iClr   = r[1];
      bus.iValid = r[2];
      bus.iReady = r[3];
      bus.iData  = r[IW+3:4];
      @(negedge iClk);
      check("rst_ovalid", 64'(bus.oValid), 64'd0);
      check("rst_odata", 64'(bus.oData), 64'd0);
    end
    bus.iEn    = 1'b1;
    bus.iClr   = 1'b0;
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iData  = '0;
    iRstN      = 1'b1;
    #1;
    check("rst_oready", 64'(bus.oReady), 64'd1);
    cycle();

    // Basic frame
    bus.iReady = 1'b1;
    exp_q.push_back(35'd10);
    for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
    #1;
    check("basic_valid", 64'(bus.oValid), 64'd1);
    check("basic_data", 64'(bus.oData), 64'd10);
    cycle();
    check("basic_one_cycle", 64'(bus.oValid), 64'd0);

    // Max width
    exp_q.push_back(35'h7_FFFF_FFFC);
    for (int i = 0; i < 4; i++) send(33'h1_FFFF_FFFF, 1'b0);
    #1;
    check("max_data", 64'(bus.oData), 64'h7_FFFF_FFFC);
    idle(2);

    // Backpressure
    bus.iReady = 1'b0;
    exp_q.push_back(35'd10);
    exp_q.push_back(35'd26);
    for (int i = 1; i <= 7; i++) send(IW'(i), 1'b0);
    #1;
    check("bp_hold_valid", 64'(bus.oValid), 64'd1);
    check("bp_hold_data", 64'(bus.oData), 64'd10);
    bus.iValid = 1'b1;
    bus.iData  = 33'd8;
    #1;
    check("bp_stall", 64'(bus.oReady), 64'd0);
    cycle();
    check("bp_stall_again", 64'(bus.oReady), 64'd0);
    check("bp_still_data", 64'(bus.oData), 64'd10);
    bus.iReady = 1'b1;
    #1;
    check("bp_release", 64'(bus.oReady), 64'd1);
    cycle();
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    #1;
    check("bp_next_valid", 64'(bus.oValid), 64'd1);
    check("bp_next_data", 64'(bus.oData), 64'd26);
    bus.iReady = 1'b1;
    cycle();
    check("bp_drained_valid", 64'(bus.oValid), 64'd0);
    check("bp_drained_q", 64'(exp_q.size()), 64'd0);

    // Clear mid-frame
    send(33'd7, 1'b0);
    send(33'd7, 1'b0);
    bus.iClr = 1'b1;
    #1;
    check("clr_oready", 64'(bus.oReady), 64'd0);
    cycle();
    bus.iClr = 1'b0;
    exp_q.push_back(35'd4);
    for (int i = 0; i < 4; i++) send(33'd1, 1'b0);
    idle(2);

    // Enable freeze mid-frame
    exp_q.push_back(35'd10);
    send(33'd1, 1'b0);
    send(33'd2, 1'b0);
    bus.iValid = 1'b1;
    bus.iData  = 33'd3;
    bus.iEn    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_oready", 64'(bus.oReady), 64'd0);
      cycle();
    end
    bus.iEn = 1'b1;
    send(33'd3, 1'b0);
    send(33'd4, 1'b0);
    idle(2);

    // Mid-frame asynchronous reset
    send(33'd5, 1'b0);
    send(33'd5, 1'b0);
    #2 iRstN = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.oValid), 64'd0);
    check("mid_rst_data", 64'(bus.oData), 64'd0);
    #2 iRstN = 1'b1;
    cycle();
    exp_q.push_back(35'd8);
    for (int i = 0; i < 4; i++) send(33'd2, 1'b0);
    #1;
    check("mid_rst_frame", 64'(bus.oData), 64'd8);
    idle(2);

    // Randomized frames with random sink backpressure
    for (int f = 0; f < 20; f++) begin
      sum = '0;
      for (int k = 0; k < 4; k++) begin
        r    = {$urandom(), $urandom()};
        d[k] = r[IW-1:0];
        sum  = sum + OW'(d[k]);
      end
      exp_q.push_back(sum);
      for (int k = 0; k < 4; k++) begin
        send(d[k], 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          bus.iReady = 1'($urandom_range(0, 1));
          cycle();
        end
      end
    end
    bus.iReady = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      cycle();
      w++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
